// File: rtl/uart_tx_if.sv
// Handshake between the debug unit (master) and the UART transmitter (slave).
// The master raises tx_start with tx_dato_in valid.
// The slave answers with a one-clk tx_done pulse and holds tx_busy high while a frame is in flight.
interface uart_tx_if #(
    parameter int D_BIT = 8
);
    logic             tx_start;
    logic [D_BIT-1:0] tx_dato_in;
    logic             tx_done;
    logic             tx_busy;

    modport master (output tx_start, output tx_dato_in, input tx_done, input tx_busy);
    modport slave  (input tx_start, input tx_dato_in, output tx_done, output tx_busy);
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter.
// Sends one start bit, D_BIT data bits LSB first, then a stop period of SB_TICK s_ticks.
// Bit timing comes from a 16x-baud s_tick pulse.
// Optional macro UART_TX_PARITY_EN inserts a 16-tick even-parity bit between the data bits and the stop period.
// The line output tx is registered and returns high asynchronously on reset.
module uart_tx #(
    parameter int D_BIT   = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     s_tick,
    uart_tx_if.slave bus,
    output logic     tx
);

    // The tick counter is 4 bits by default; it widens only when the stop period needs more than 16 ticks.
    localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int BW = (D_BIT > 1) ? $clog2(D_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(15);
    localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(D_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [D_BIT-1:0] shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Next-state, counters and datapath; tx is derived from the upcoming state so the line is registered.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                // A request seen while tx_done is still high belongs to the frame that just ended.
                if (bus.tx_start && !done_q) begin
                    shreg_d = bus.tx_dato_in;
                    tick_d  = '0;
                    busy_d  = 1'b1;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.tx_dato_in;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = {1'b0, shreg_q[D_BIT-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d  = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            default: begin
                // Unreachable encodings recover to an idle, high line.
                tick_d  = '0;
                bit_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State register and datapath; reset abandons any frame and forces the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx          = tx_q;
    assign bus.tx_done = done_q;
    assign bus.tx_busy = busy_q;

endmodule
